// File: rtl/m_rst_pkg.sv
// Shared types and limits for the sequenced reset controller and its synchroniser.
// Reusable by any reset domain that needs the same state encoding.
package m_rst_pkg;

  localparam int STATE_W  = 2;
  localparam int MAX_OUT  = 16;
  localparam int MIN_SYNC = 2;

  typedef enum logic [STATE_W-1:0] {
    RST_ASSERT  = 2'd0,
    RST_RELEASE = 2'd1,
    RST_RUN     = 2'd2,
    RST_SW_HOLD = 2'd3
  } rst_state_t;

  // The counter must hold the larger of the two terminal counts.
  function automatic int cnt_width(input int stretch, input int stagger);
    int m;
    m = (stretch > stagger) ? stretch : stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/m_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; rn_sync rises STAGES edges after rn releases.
// No flow control: a plain flop chain with D tied high.
module m_rst_sync
  import m_rst_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic rn,
  output logic rn_sync
);

  if (STAGES < MIN_SYNC) begin : g_bad_stages
    $error("m_rst_sync: STAGES must be >= %0d", MIN_SYNC);
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rn_sync = chain[STAGES-1];

endmodule

// File: rtl/m_rst_ctrl.sv
// Sequenced reset generator: async assert, synchronised/stretched/staggered release, bit 0 first.
// Software reset handshake (REQ/ACK) present only when M_RST_CTRL_SW_RST_EN is defined.
module m_rst_ctrl
  import m_rst_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               SW_RST_REQ,
  output logic               SW_RST_ACK,
  output logic [NUM_OUT-1:0] RST_N_OUT,
  output logic               RST_DONE
);

  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("m_rst_ctrl: NUM_OUT must be in 1..%0d", MAX_OUT);
  end
  if (SYNC_STAGES < MIN_SYNC) begin : g_bad_sync
    $error("m_rst_ctrl: SYNC_STAGES must be >= %0d", MIN_SYNC);
  end
  if (STRETCH_CYC < 1) begin : g_bad_stretch
    $error("m_rst_ctrl: STRETCH_CYC must be >= 1");
  end
  if (STAGGER_CYC < 1) begin : g_bad_stagger
    $error("m_rst_ctrl: STAGGER_CYC must be >= 1");
  end

  localparam int                 CNT_W        = cnt_width(STRETCH_CYC, STAGGER_CYC);
  localparam logic [CNT_W-1:0]   STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [NUM_OUT-1:0] OUT_FIRST    = NUM_OUT'(1);

  logic               rn_sync;
  rst_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_OUT-1:0] rst_n_r;
  logic [NUM_OUT-1:0] rst_n_shift;
  logic               done_r;

  m_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .ck      (CK),
    .rn      (RN),
    .rn_sync (rn_sync)
  );

  // Outputs fill from bit 0 upward, so the sequence is complete when every bit is set.
  assign rst_n_shift = (rst_n_r << 1) | OUT_FIRST;

`ifdef M_RST_CTRL_SW_RST_EN
  logic ack_r;
  assign SW_RST_ACK = ack_r;
`else
  logic sw_req_unused;
  assign sw_req_unused = SW_RST_REQ;
  assign SW_RST_ACK    = 1'b0;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= RST_ASSERT;
      cnt     <= '0;
      rst_n_r <= '0;
      done_r  <= 1'b0;
`ifdef M_RST_CTRL_SW_RST_EN
      ack_r   <= 1'b0;
`endif
    end else begin
      case (state)
        RST_ASSERT: begin
          rst_n_r <= '0;
          done_r  <= 1'b0;
          // Stretch only counts once the raw reset release has crossed the synchroniser.
          if (rn_sync) begin
            if (cnt == STRETCH_LAST) begin
              cnt     <= '0;
              rst_n_r <= OUT_FIRST;
              if (NUM_OUT == 1) begin
                done_r <= 1'b1;
                state  <= RST_RUN;
              end else begin
                state  <= RST_RELEASE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        RST_RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            cnt     <= '0;
            rst_n_r <= rst_n_shift;
            if (&rst_n_shift) begin
              done_r <= 1'b1;
              state  <= RST_RUN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RST_RUN: begin
`ifdef M_RST_CTRL_SW_RST_EN
          if (SW_RST_REQ) begin
            rst_n_r <= '0;
            done_r  <= 1'b0;
            ack_r   <= 1'b1;
            state   <= RST_SW_HOLD;
          end
`endif
        end

        RST_SW_HOLD: begin
`ifdef M_RST_CTRL_SW_RST_EN
          // Release restarts from the stretch phase; the synchroniser is already settled.
          if (!SW_RST_REQ) begin
            ack_r <= 1'b0;
            cnt   <= '0;
            state <= RST_ASSERT;
          end
`else
          state <= RST_ASSERT;
`endif
        end

        default: begin
          cnt     <= '0;
          rst_n_r <= '0;
          done_r  <= 1'b0;
          state   <= RST_ASSERT;
        end
      endcase
    end
  end

  assign RST_N_OUT = rst_n_r;
  assign RST_DONE  = done_r;

endmodule
